// File: rtl/sim_ahb_splitter.sv
// AHB-Lite 1-to-2 address decoder/splitter with a data-phase tracker that
// steers the response mux and generates the two-cycle error response for unmapped transfers.
module sim_ahb_splitter #(
  parameter int                 W_ADDR  = 32,
  parameter int                 W_DATA  = 32,
  parameter logic [W_ADDR-1:0]  S0_BASE = 32'h0000_0000,
  parameter logic [W_ADDR-1:0]  S0_MASK = 32'hf000_0000,
  parameter logic [W_ADDR-1:0]  S1_BASE = 32'h8000_0000,
  parameter logic [W_ADDR-1:0]  S1_MASK = 32'hf000_0000
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 ahbls_hready,
  output logic                 ahbls_hready_resp,
  output logic                 ahbls_hresp,
  input  logic [W_ADDR-1:0]    ahbls_haddr,
  input  logic                 ahbls_hwrite,
  input  logic [1:0]           ahbls_htrans,
  input  logic [2:0]           ahbls_hsize,
  input  logic [2:0]           ahbls_hburst,
  input  logic [3:0]           ahbls_hprot,
  input  logic                 ahbls_hmastlock,
  input  logic [W_DATA-1:0]    ahbls_hwdata,
  output logic [W_DATA-1:0]    ahbls_hrdata,

  output logic [1:0]           ahblm_hsel,
  output logic                 ahblm_hready,
  output logic [W_ADDR-1:0]    ahblm_haddr,
  output logic                 ahblm_hwrite,
  output logic [1:0]           ahblm_htrans,
  output logic [2:0]           ahblm_hsize,
  output logic [2:0]           ahblm_hburst,
  output logic [3:0]           ahblm_hprot,
  output logic                 ahblm_hmastlock,
  output logic [W_DATA-1:0]    ahblm_hwdata,
  input  logic [1:0]           ahblm_hready_resp,
  input  logic [1:0]           ahblm_hresp,
  input  logic [2*W_DATA-1:0]  ahblm_hrdata,

  output logic [7:0]           err_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] err_count_q, err_count_d;
  logic       hit0, hit1;

  // Slave 0 takes priority when both windows match.
  assign hit0 = (ahbls_haddr & S0_MASK) == S0_BASE;
  assign hit1 = ((ahbls_haddr & S1_MASK) == S1_BASE) && !hit0;

  assign ahblm_hsel      = {hit1 & ahbls_htrans[1], hit0 & ahbls_htrans[1]};
  assign ahblm_hready    = ahbls_hready;
  assign ahblm_haddr     = ahbls_haddr;
  assign ahblm_hwrite    = ahbls_hwrite;
  assign ahblm_htrans    = ahbls_htrans;
  assign ahblm_hsize     = ahbls_hsize;
  assign ahblm_hburst    = ahbls_hburst;
  assign ahblm_hprot     = ahbls_hprot;
  assign ahblm_hmastlock = ahbls_hmastlock;
  assign ahblm_hwdata    = ahbls_hwdata;

  // ERR1 always moves on: upstream HREADY is low there, so it cannot gate the step.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    err_count_d = err_count_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (ahbls_hready) begin
      if (!ahbls_htrans[1]) begin
        state_d = ST_IDLE;
      end else if (hit0) begin
        state_d = ST_S0;
      end else if (hit1) begin
        state_d = ST_S1;
      end else begin
        state_d = ST_ERR1;
        if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    ahbls_hrdata      = '0;
    case (state_q)
      ST_S0: begin
        ahbls_hready_resp = ahblm_hready_resp[0];
        ahbls_hresp       = ahblm_hresp[0];
        ahbls_hrdata      = ahblm_hrdata[W_DATA-1:0];
      end
      ST_S1: begin
        ahbls_hready_resp = ahblm_hready_resp[1];
        ahbls_hresp       = ahblm_hresp[1];
        ahbls_hrdata      = ahblm_hrdata[2*W_DATA-1:W_DATA];
      end
      ST_ERR1: begin
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = 1'b1;
      end
      ST_ERR2: begin
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = 1'b1;
      end
      default: ;
    endcase
  end

  assign err_count = err_count_q;

endmodule

// File: tb/tb_sim_ahb_splitter.sv
// Directed bench for sim_ahb_splitter: a cycle-by-cycle vector table for decode and
// response steering, plus hand sequences for reset, pass-through and counter saturation.
module tb_sim_ahb_splitter;

  localparam logic [31:0] S0_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] S1_DATA = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst;
  logic        ahbls_hready;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic [31:0] ahbls_haddr;
  logic        ahbls_hwrite;
  logic [1:0]  ahbls_htrans;
  logic [2:0]  ahbls_hsize;
  logic [2:0]  ahbls_hburst;
  logic [3:0]  ahbls_hprot;
  logic        ahbls_hmastlock;
  logic [31:0] ahbls_hwdata;
  logic [31:0] ahbls_hrdata;
  logic [1:0]  ahblm_hsel;
  logic        ahblm_hready;
  logic [31:0] ahblm_haddr;
  logic        ahblm_hwrite;
  logic [1:0]  ahblm_htrans;
  logic [2:0]  ahblm_hsize;
  logic [2:0]  ahblm_hburst;
  logic [3:0]  ahblm_hprot;
  logic        ahblm_hmastlock;
  logic [31:0] ahblm_hwdata;
  logic [1:0]  ahblm_hready_resp;
  logic [1:0]  ahblm_hresp;
  logic [63:0] ahblm_hrdata;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sim_ahb_splitter dut (
    .clk               (clk),
    .rst               (rst),
    .ahbls_hready      (ahbls_hready),
    .ahbls_hready_resp (ahbls_hready_resp),
    .ahbls_hresp       (ahbls_hresp),
    .ahbls_haddr       (ahbls_haddr),
    .ahbls_hwrite      (ahbls_hwrite),
    .ahbls_htrans      (ahbls_htrans),
    .ahbls_hsize       (ahbls_hsize),
    .ahbls_hburst      (ahbls_hburst),
    .ahbls_hprot       (ahbls_hprot),
    .ahbls_hmastlock   (ahbls_hmastlock),
    .ahbls_hwdata      (ahbls_hwdata),
    .ahbls_hrdata      (ahbls_hrdata),
    .ahblm_hsel        (ahblm_hsel),
    .ahblm_hready      (ahblm_hready),
    .ahblm_haddr       (ahblm_haddr),
    .ahblm_hwrite      (ahblm_hwrite),
    .ahblm_htrans      (ahblm_htrans),
    .ahblm_hsize       (ahblm_hsize),
    .ahblm_hburst      (ahblm_hburst),
    .ahblm_hprot       (ahblm_hprot),
    .ahblm_hmastlock   (ahblm_hmastlock),
    .ahblm_hwdata      (ahblm_hwdata),
    .ahblm_hready_resp (ahblm_hready_resp),
    .ahblm_hresp       (ahblm_hresp),
    .ahblm_hrdata      (ahblm_hrdata),
    .err_count         (err_count)
  );

  // One row = one clock: inputs driven before the edge, outputs checked in the same cycle.
  typedef struct {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic [1:0]  s_ready;
    logic [1:0]  s_resp;
    logic [1:0]  exp_hsel;
    logic        exp_ready;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic hr);
    ahbls_haddr  = a;
    ahbls_htrans = t;
    ahbls_hready = hr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(32'h0, 2'b00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] pack_out();
    return {20'd0, ahblm_hsel, ahbls_hready_resp, ahbls_hresp, ahbls_hrdata, err_count};
  endfunction

  function automatic logic [63:0] pack_exp(input vec_t v);
    return {20'd0, v.exp_hsel, v.exp_ready, v.exp_resp, v.exp_rdata, v.exp_err};
  endfunction

  initial begin
    //            haddr          trans  hrdy sready sresp  hsel   rdy resp rdata     err
    vecs[0]  = '{32'h8000_0000, 2'b10, 1'b1, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0, 32'h0,   8'd0};
    vecs[1]  = '{32'h0000_0010, 2'b10, 1'b1, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, S1_DATA, 8'd0};
    vecs[2]  = '{32'h8000_0004, 2'b10, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, S0_DATA, 8'd0};
    vecs[3]  = '{32'h8000_0004, 2'b10, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, S0_DATA, 8'd0};
    vecs[4]  = '{32'h8000_0004, 2'b10, 1'b1, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0, S0_DATA, 8'd0};
    vecs[5]  = '{32'h4000_0000, 2'b10, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, S1_DATA, 8'd0};
    vecs[6]  = '{32'h4000_0000, 2'b10, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0,   8'd1};
    vecs[7]  = '{32'h4000_0000, 2'b00, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 32'h0,   8'd1};
    vecs[8]  = '{32'h4000_0000, 2'b00, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0,   8'd1};
    vecs[9]  = '{32'h4000_0000, 2'b01, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0,   8'd1};
    vecs[10] = '{32'h0000_0000, 2'b11, 1'b1, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 32'h0,   8'd1};
    vecs[11] = '{32'h8000_0000, 2'b10, 1'b0, 2'b10, 2'b01, 2'b10, 1'b0, 1'b1, S0_DATA, 8'd1};
    vecs[12] = '{32'h8000_0000, 2'b00, 1'b1, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, S0_DATA, 8'd1};
    vecs[13] = '{32'h4000_0000, 2'b10, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0,   8'd1};
    vecs[14] = '{32'h4000_0000, 2'b00, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0,   8'd1};

    rst               = 1'b1;
    ahbls_hwrite      = 1'b0;
    ahbls_hsize       = 3'd2;
    ahbls_hburst      = 3'd0;
    ahbls_hprot       = 4'h3;
    ahbls_hmastlock   = 1'b0;
    ahbls_hwdata      = 32'h0;
    ahblm_hready_resp = 2'b11;
    ahblm_hresp       = 2'b00;
    ahblm_hrdata      = {S1_DATA, S0_DATA};
    drive(32'h0, 2'b00, 1'b1);

    do_reset();
    #1;
    check("reset_outputs", {ahbls_hready_resp, ahbls_hresp, ahbls_hrdata, err_count},
          {1'b1, 1'b0, 32'h0, 8'd0});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].haddr, vecs[i].htrans, vecs[i].hready);
      ahblm_hready_resp = vecs[i].s_ready;
      ahblm_hresp       = vecs[i].s_resp;
      #1;
      check($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
    end

    // Write to slave 1: request broadcast in address phase, write data seen next cycle.
    do_reset();
    ahblm_hresp       = 2'b00;
    ahblm_hready_resp = 2'b11;
    drive(32'h8000_0000, 2'b10, 1'b1);
    ahbls_hwrite = 1'b1;
    #1;
    check("wr_addr_phase", {ahblm_hsel, ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hready},
          {2'b10, 32'h8000_0000, 1'b1, 2'b10, 1'b1});
    @(negedge clk);
    drive(32'h0, 2'b00, 1'b1);
    ahbls_hwrite = 1'b0;
    ahbls_hwdata = 32'h41;
    #1;
    check("wr_data_phase", {ahblm_hwdata, ahbls_hresp, ahbls_hready_resp},
          {32'h41, 1'b0, 1'b1});
    check("hprot_hsize_passthru", {ahblm_hprot, ahblm_hsize, ahblm_hburst, ahblm_hmastlock},
          {4'h3, 3'd2, 3'd0, 1'b0});

    // Reset asserted while in ERR1 overrides the error response.
    do_reset();
    drive(32'h4000_0000, 2'b10, 1'b1);
    @(negedge clk);
    ahbls_hready = 1'b0;
    #1;
    check("err1_before_rst", {ahbls_hready_resp, ahbls_hresp, err_count}, {1'b0, 1'b1, 8'd1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(32'h0, 2'b00, 1'b1);
    #1;
    check("rst_in_err1", {ahbls_hready_resp, ahbls_hresp, err_count}, {1'b1, 1'b0, 8'd0});

    // Reset during a slave wait state.
    drive(32'h0000_0020, 2'b10, 1'b1);
    @(negedge clk);
    ahblm_hready_resp = 2'b10;
    ahbls_hready      = 1'b0;
    #1;
    check("s0_wait", {ahbls_hready_resp, ahbls_hrdata}, {1'b0, S0_DATA});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(32'h0, 2'b00, 1'b1);
    #1;
    check("rst_in_wait", {ahbls_hready_resp, ahbls_hrdata}, {1'b1, 32'h0});
    ahblm_hready_resp = 2'b11;

    // Back-to-back unmapped NONSEQ: each transfer is ERR1 then ERR2.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      drive(32'h4000_0000 + 32'(k * 4), 2'b10, 1'b1);
      @(negedge clk);
      ahbls_hready = 1'b0;
      @(negedge clk);
      if (k == 9) check("err_count_10", {56'd0, err_count}, 64'd10);
      if (k == 254) check("err_count_255", {56'd0, err_count}, 64'd255);
    end
    drive(32'h0, 2'b00, 1'b1);
    #1;
    check("err_count_sat", {56'd0, err_count}, 64'hff);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
